// File: rtl/jam_cost_server.sv
// Responder for the JAM worker/job interface: holds the 8x8 cost matrix, gates JAM's reset and captures its result.
// Optional watchdog: define JAM_TIMEOUT_EN to end a RUN after TIMEOUT_CYCLES cycles without a result.
module jam_cost_server #(
  parameter int TIMEOUT_CYCLES = 400000,
  parameter int CNT_W          = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_valid,
  input  logic [6:0]       load_data,
  output logic             load_ready,
  input  logic             restart,
  input  logic             rerun,
  output logic             jam_rst,
  input  logic [2:0]       W,
  input  logic [2:0]       J,
  output logic [6:0]       Cost,
  input  logic [3:0]       MatchCount,
  input  logic [9:0]       MinCost,
  input  logic             Valid,
  output logic             done,
  output logic [9:0]       result_mincost,
  output logic [3:0]       result_matchcount,
  output logic [CNT_W-1:0] run_cycles,
  output logic             timeout
);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;

  if (TIMEOUT_CYCLES > (2 ** CNT_W) - 1) begin : g_cnt_w_check
    $error("CNT_W too narrow to hold TIMEOUT_CYCLES");
  end

  state_t           r_state;
  logic [5:0]       r_addr;
  logic [6:0]       r_table [64];
  logic             r_jam_rst;
  logic             r_load_ready;
  logic             r_done;
  logic [9:0]       r_mincost;
  logic [3:0]       r_matchcount;
  logic [CNT_W-1:0] r_run_cycles;
  logic             w_capture;
  logic [CNT_W-1:0] w_rc_next;

  // JAM's result only counts once it has seen at least one reset edge.
  assign w_capture = Valid && !r_jam_rst;
  assign w_rc_next = (r_run_cycles == '1) ? r_run_cycles : r_run_cycles + 1'b1;

`ifdef JAM_TIMEOUT_EN
  logic r_timeout;
  logic w_expire;
  assign w_expire = (r_run_cycles == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout  = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (r_state == S_LOAD && load_valid)
      r_table[r_addr] <= load_data;
  end

  assign Cost = r_table[{W, J}];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_LOAD;
      r_addr       <= '0;
      r_jam_rst    <= 1'b1;
      r_load_ready <= 1'b1;
      r_done       <= 1'b0;
      r_mincost    <= '0;
      r_matchcount <= '0;
      r_run_cycles <= '0;
`ifdef JAM_TIMEOUT_EN
      r_timeout    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_LOAD: begin
          if (load_valid) begin
            r_addr <= r_addr + 6'd1;
            if (r_addr == 6'd63) begin
              r_state      <= S_RUN;
              r_load_ready <= 1'b0;
              r_run_cycles <= '0;
            end
          end
        end
        S_RUN: begin
          r_run_cycles <= w_rc_next;
          if (w_capture) begin
            r_mincost    <= MinCost;
            r_matchcount <= MatchCount;
            r_done       <= 1'b1;
            r_jam_rst    <= 1'b1;
            r_state      <= S_DONE;
          end
`ifdef JAM_TIMEOUT_EN
          else if (w_expire) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_jam_rst <= 1'b1;
            r_state   <= S_DONE;
          end
`endif
          else begin
            r_jam_rst <= 1'b0;
          end
        end
        S_DONE: begin
          if (restart) begin
            r_state      <= S_LOAD;
            r_done       <= 1'b0;
            r_addr       <= '0;
            r_load_ready <= 1'b1;
`ifdef JAM_TIMEOUT_EN
            r_timeout    <= 1'b0;
`endif
          end else if (rerun) begin
            r_state      <= S_RUN;
            r_done       <= 1'b0;
            r_run_cycles <= '0;
`ifdef JAM_TIMEOUT_EN
            r_timeout    <= 1'b0;
`endif
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign jam_rst           = r_jam_rst;
  assign load_ready        = r_load_ready;
  assign done              = r_done;
  assign result_mincost    = r_mincost;
  assign result_matchcount = r_matchcount;
  assign run_cycles        = r_run_cycles;

endmodule

// File: doc/jam_cost_server.md
Name: jam_cost_server

Overview:
- Responder side of the JAM worker/job assignment interface.
- Holds the 8x8 cost matrix and answers the W/J address with Cost in the same cycle.
- Holds JAM in reset until the matrix is loaded, then releases it.
- Captures JAM's MinCost/MatchCount when Valid pulses and reports run length.

Parameters:
- TIMEOUT_CYCLES, 400000: RUN-cycle limit, used only with JAM_TIMEOUT_EN.
- CNT_W, 20: width of the run cycle counter; must hold TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- load_valid  in  1  load word present
- load_data  in  7  cost word, row-major: word k = cost[W=k/8][J=k%8]
- load_ready  out  1  server accepts load words
- restart  in  1  pulse in DONE: go back to LOAD for a new matrix
- rerun  in  1  pulse in DONE: rerun JAM on the stored matrix
- jam_rst  out  1  drives JAM's RST
- W  in  3  worker index from JAM
- J  in  3  job index from JAM
- Cost  out  7  cost[W][J]
- MatchCount  in  4  from JAM
- MinCost  in  10  from JAM
- Valid  in  1  from JAM, result strobe
- done  out  1  result captured (level)
- result_mincost  out  10  captured MinCost
- result_matchcount  out  4  captured MatchCount
- run_cycles  out  CNT_W  cycles spent in RUN for the last run
- timeout  out  1  watchdog flag; tied 0 without JAM_TIMEOUT_EN

Behaviour:
- Storage: 64 x 7-bit register array, not reset. Contents are undefined after RST until reloaded.
- FSM states: LOAD, RUN, DONE. Reset state is LOAD.
- Reset values: jam_rst=1, load_ready=1, done=0, result_mincost=0, result_matchcount=0, run_cycles=0, timeout=0, load address=0.
- LOAD:
  - load_ready=1. Each cycle with load_valid=1 writes table[addr] and increments the 6-bit addr.
  - Gaps in load_valid are allowed.
  - The write at addr=63 wraps addr to 0 and moves to RUN on the next edge.
  - restart and rerun are ignored.
- RUN:
  - load_ready=0; load_valid is ignored.
  - jam_rst is registered. It stays 1 for the first RUN cycle and is 0 from the second RUN cycle onward, so JAM always sees at least one reset edge.
  - run_cycles clears on RUN entry and increments every RUN cycle, saturating at all-ones.
  - Valid sampled 1 while jam_rst=0: capture MinCost->result_mincost and MatchCount->result_matchcount, set done=1, set jam_rst=1, go to DONE. The capture happens on that same edge.
  - Valid sampled while jam_rst=1 is ignored.
- Cost: purely combinational, Cost = table[{W,J}] in every state, with zero-latency read. JAM adds Cost in the cycle it drives W/J.
- DONE:
  - done=1, jam_rst=1; results and run_cycles are held.
  - rerun=1: go to RUN, done->0, run_cycles->0.
  - restart=1: go to LOAD, done->0, addr->0.
  - rerun and restart both 1: restart wins.
- RST asserted mid-load or mid-run: immediate return to reset values. A partially loaded table stays undefined, and the next load starts at addr 0.
- Widths: result registers copy the input widths exactly; no arithmetic on the cost data path.

Optional Feature:
- Macro: JAM_TIMEOUT_EN.
- Defined:
  - When run_cycles reaches TIMEOUT_CYCLES in RUN without a captured Valid: set timeout=1, force jam_rst=1, go to DONE.
  - In this case done=1 and the result registers keep their previous values.
  - timeout clears on leaving DONE or on RST.
- Undefined: no comparator; timeout is tied 0 and RUN waits indefinitely.

Test Plan:
- Diagonal matrix, cost[w][j]=0 if w==j else 10, loaded with random load_valid gaps, real JAM attached -> done=1, result_mincost=0, result_matchcount=1, run_cycles=362884 +/- JAM start offset. Record the exact value once; later regressions compare to it.
- Matrix cost[w][j]=w*8+j (0..63); drive W=3, J=5 directly with JAM stubbed -> Cost=29 combinationally in the same cycle. W=7, J=7 -> Cost=63.
- After load, jam_rst=1 exactly one cycle into RUN, then 0. A stub asserting Valid while jam_rst=1 is ignored; Valid with MinCost=123, MatchCount=4 after release -> result_mincost=123, result_matchcount=4, done=1 on the next edge.
- In DONE, pulse rerun -> RUN on the stored table, repeated diagonal run gives identical results. Pulse rerun and restart together -> LOAD, load_ready=1.
- Assert RST after 20 load words, release, load 64 fresh words -> table holds only the fresh words (table[0]=first new word), and RUN is entered after exactly 64 accepted words.
- JAM_TIMEOUT_EN, TIMEOUT_CYCLES=100, stub never asserts Valid -> timeout=1, done=1 after 100 RUN cycles, results unchanged (0/0). restart clears timeout.
